// File: rtl/serial_pkg.sv
// Types and defaults shared by the serial transmitter and the sequence detector.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } state_e;

  localparam int         DATA_W_DEF   = 8;
  localparam int         SYNC_W_DEF   = 4;
  localparam logic [3:0] SYNC_PAT_DEF = 4'b1011;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in / serial-out register: load wins over shift, zero-filled left shift,
// MSB exposed as the serial tap.
module piso_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data_in,
  output logic              msb
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = data_in;
    end else if (shift) begin
      data_d = {data_q[DATA_W-2:0], 1'b0};
    end else begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb = data_q[DATA_W-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Framed serial transmitter: sync pattern, payload MSB first, even parity bit.
// All outputs are registered; next-cycle output values are computed alongside next state.
module serial_pattern_tx
  import serial_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                SYNC_W   = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              done
);

  localparam int CNT_MAX = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  function automatic logic even_par(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  // Shift-based select keeps the index width independent of SYNC_W.
  function automatic logic sync_bit(input logic [CNT_W-1:0] idx);
    logic [SYNC_W-1:0] sh;
    sh = SYNC_PAT >> idx;
    return sh[0];
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             ready_q, ready_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             shreg_load_s;
  logic             shreg_shift_s;
  logic             shreg_msb_s;

  piso_shift #(.DATA_W(DATA_W)) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load    (shreg_load_s),
    .shift   (shreg_shift_s),
    .data_in (data_in),
    .msb     (shreg_msb_s)
  );

  // The bit registered on each edge is the one shown during the following cycle,
  // so the shift register advances on the same edge that its MSB is taken.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    par_d         = par_q;
    ready_d       = 1'b0;
    dout_d        = 1'b0;
    valid_d       = 1'b0;
    done_d        = 1'b0;
    shreg_load_s  = 1'b0;
    shreg_shift_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d      = SYNC;
          cnt_d        = '0;
          par_d        = even_par(data_in);
          shreg_load_s = 1'b1;
          dout_d       = sync_bit(SYNC_LAST);
          valid_d      = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      SYNC: begin
        valid_d = 1'b1;
        if (cnt_q == SYNC_LAST) begin
          state_d       = DATA;
          cnt_d         = '0;
          dout_d        = shreg_msb_s;
          shreg_shift_s = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          dout_d = sync_bit(SYNC_LAST - cnt_q - CNT_W'(1));
        end
      end
      DATA: begin
        valid_d = 1'b1;
        if (cnt_q == DATA_LAST) begin
          state_d = PAR;
          cnt_d   = '0;
          dout_d  = par_q;
        end else begin
          cnt_d         = cnt_q + CNT_W'(1);
          dout_d        = shreg_msb_s;
          shreg_shift_s = 1'b1;
        end
      end
      PAR: begin
        state_d = IDLE;
        cnt_d   = '0;
        ready_d = 1'b1;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      ready_q <= 1'b1;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign ready      = ready_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: expected frame bits are queued at load
// time and popped as the serial output is sampled on the falling edge.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] data_in;
  logic       ready;
  logic       dout;
  logic       dout_valid;
  logic       done;

  logic       exp_q[$];
  logic       exp_b;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  serial_pattern_tx dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .ready      (ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected frame: sync 1011, payload MSB first, even parity over the payload.
  task automatic push_frame(input logic [7:0] d);
    logic [3:0] pat;
    pat = 4'b1011;
    for (int s = 3; s >= 0; s--) exp_q.push_back(pat[s]);
    for (int b = 7; b >= 0; b--) exp_q.push_back(d[b]);
    exp_q.push_back(^d);
  endtask

  // Called on a falling edge; returns on the falling edge of the first frame bit.
  task automatic start_load(input logic [7:0] d);
    load    = 1'b1;
    data_in = d;
    push_frame(d);
    @(negedge clk);
    load    = 1'b0;
    data_in = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; data_in = 8'hA5;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({ready, dout, dout_valid, done} !== 4'b1000) begin
      err_cnt++;
      $display("FAIL reset_outputs: ready,dout,valid,done=%b expected 1000", {ready, dout, dout_valid, done});
    end
    rst = 1'b0; load = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vec_cnt++;
      if ({ready, dout_valid, done} !== 3'b100) begin
        err_cnt++;
        $display("FAIL reset_no_frame: ready,valid,done=%b expected 100", {ready, dout_valid, done});
      end
    end
  endtask

  task automatic test_single_frame();
    @(negedge clk);
    start_load(8'hA5);
    vec_cnt++;
    if (ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_ready_low: ready=%b expected 0", ready);
    end
    for (int i = 0; i < 13; i++) begin
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
      vec_cnt++;
      if (dout_valid !== 1'b1 || dout !== exp_b) begin
        err_cnt++;
        $display("FAIL single_a5 bit %0d: dout=%b valid=%b expected dout=%b valid=1", i, dout, dout_valid, exp_b);
      end
      @(negedge clk);
    end
    vec_cnt++;
    if ({done, ready, dout_valid, dout} !== 4'b1100) begin
      err_cnt++;
      $display("FAIL single_done: done,ready,valid,dout=%b expected 1100", {done, ready, dout_valid, dout});
    end
    @(negedge clk);
    vec_cnt++;
    if ({done, ready} !== 2'b01) begin
      err_cnt++;
      $display("FAIL single_done_pulse: done,ready=%b expected 01", {done, ready});
    end
  endtask

  task automatic test_parity();
    logic [7:0] words [3] = '{8'h01, 8'hFF, 8'h00};
    logic       pars  [3] = '{1'b1, 1'b0, 1'b0};
    for (int w = 0; w < 3; w++) begin
      start_load(words[w]);
      for (int i = 0; i < 13; i++) begin
        exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
        vec_cnt++;
        if (dout_valid !== 1'b1 || dout !== exp_b) begin
          err_cnt++;
          $display("FAIL parity_%h bit %0d: dout=%b valid=%b expected dout=%b valid=1", words[w], i, dout, dout_valid, exp_b);
        end
        if (i == 12) begin
          vec_cnt++;
          if (dout !== pars[w]) begin
            err_cnt++;
            $display("FAIL parity_bit_%h: got %b expected %b", words[w], dout, pars[w]);
          end
        end
        @(negedge clk);
      end
      vec_cnt++;
      if (done !== 1'b1) begin
        err_cnt++;
        $display("FAIL parity_done_%h: done=%b expected 1", words[w], done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_load();
    start_load(8'hA5);
    for (int i = 0; i < 13; i++) begin
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
      vec_cnt++;
      if (dout_valid !== 1'b1 || dout !== exp_b) begin
        err_cnt++;
        $display("FAIL busy_a5 bit %0d: dout=%b valid=%b expected dout=%b valid=1", i, dout, dout_valid, exp_b);
      end
      if (i == 9) begin
        load = 1'b1; data_in = 8'h3C;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    vec_cnt++;
    if ({done, ready} !== 2'b11) begin
      err_cnt++;
      $display("FAIL busy_done: done,ready=%b expected 11", {done, ready});
    end
    repeat (3) begin
      @(negedge clk);
      vec_cnt++;
      if ({dout_valid, ready} !== 2'b01) begin
        err_cnt++;
        $display("FAIL busy_not_queued: valid,ready=%b expected 01", {dout_valid, ready});
      end
    end
  endtask

  task automatic test_back_to_back();
    start_load(8'hA5);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 13; i++) begin
        exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
        vec_cnt++;
        if (dout_valid !== 1'b1 || dout !== exp_b) begin
          err_cnt++;
          $display("FAIL b2b frame %0d bit %0d: dout=%b valid=%b expected dout=%b valid=1", f, i, dout, dout_valid, exp_b);
        end
        @(negedge clk);
      end
      vec_cnt++;
      if ({done, ready, dout_valid} !== 3'b110) begin
        err_cnt++;
        $display("FAIL b2b_done %0d: done,ready,valid=%b expected 110", f, {done, ready, dout_valid});
      end
      if (f == 0) start_load(8'h81);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_frame_reset();
    start_load(8'hA5);
    for (int i = 0; i < 8; i++) begin
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
      vec_cnt++;
      if (dout_valid !== 1'b1 || dout !== exp_b) begin
        err_cnt++;
        $display("FAIL abort_a5 bit %0d: dout=%b valid=%b expected dout=%b valid=1", i, dout, dout_valid, exp_b);
      end
      if (i == 7) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    exp_q.delete();
    vec_cnt++;
    if ({ready, dout, dout_valid, done} !== 4'b1000) begin
      err_cnt++;
      $display("FAIL abort_reset: ready,dout,valid,done=%b expected 1000", {ready, dout, dout_valid, done});
    end
    repeat (8) begin
      @(negedge clk);
      vec_cnt++;
      if ({done, dout_valid} !== 2'b00) begin
        err_cnt++;
        $display("FAIL abort_no_done: done,valid=%b expected 00", {done, dout_valid});
      end
    end
    start_load(8'h0F);
    for (int i = 0; i < 13; i++) begin
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
      vec_cnt++;
      if (dout_valid !== 1'b1 || dout !== exp_b) begin
        err_cnt++;
        $display("FAIL after_abort_0f bit %0d: dout=%b valid=%b expected dout=%b valid=1", i, dout, dout_valid, exp_b);
      end
      @(negedge clk);
    end
    vec_cnt++;
    if ({done, ready} !== 2'b11) begin
      err_cnt++;
      $display("FAIL after_abort_done: done,ready=%b expected 11", {done, ready});
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_busy_load();
    test_back_to_back();
    test_mid_frame_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

- Framed serial transmitter: accepts a parallel word with a load/ready handshake and shifts out one bit per clock.
- Frame format: fixed sync pattern, then the data word MSB first, then an even-parity bit.
- It is the source end of the team's serial sequence-detector path.
- `dout` drives the detector's `din` directly; the detector keys on the sync pattern.

## Interface
- `DATA_W`, default 8: payload width in bits (≥2).
- `SYNC_W`, default 4: sync pattern width in bits (≥1).
- `SYNC_PAT`, default 4'b1011: sync pattern, sent MSB first.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `load` input, 1 bit: request to send `data_in`.
- `data_in` input, `DATA_W` bits: payload. Sampled only on an accepted load.
- `ready` output, 1 bit: high when a load will be accepted (IDLE only).
- `dout` output, 1 bit: serial bit.
- `dout_valid` output, 1 bit: high while `dout` carries a frame bit.
- `done` output, 1 bit: one-cycle pulse after the last bit of a frame.

## Operation
- FSM has four states: IDLE, SYNC, DATA, PAR.
- **IDLE**
  - `ready`=1, `dout`=0, `dout_valid`=0.
  - `load`=1 at an edge: capture `data_in` into the shift register, clear the bit counter, go to SYNC.
- **SYNC**
  - `dout` = `SYNC_PAT[SYNC_W-1-cnt]`, `dout_valid`=1.
  - Stays `SYNC_W` cycles, then goes to DATA with the counter cleared.
- **DATA**
  - `dout` = shift register MSB; the register shifts left, zero-filled, each cycle.
  - Stays `DATA_W` cycles, then goes to PAR.
- **PAR**
  - `dout` = XOR-reduction of the captured word, giving even parity over the payload.
  - Stays 1 cycle, then goes to IDLE.
  - Parity comes from a registered copy taken at load, not from the shifted register.
- `done` is registered. It is 1 for exactly the first IDLE cycle after PAR, and 0 otherwise.
- `load` is ignored while `ready`=0, with no queuing. `data_in` changes outside an accepted load have no effect.
- The counter width is `$clog2(max(SYNC_W, DATA_W))`. It never wraps within a state: exit happens at count = width−1.
- The payload is not escaped. A sync pattern inside the data is transmitted unchanged.

## Timing
- Reset values: state=IDLE, `ready`=1, `dout`=0, `dout_valid`=0, `done`=0, counter=0, shift register=0.
- Load accepted at edge N: the first sync bit appears after edge N, and `ready` falls to 0 after edge N.
- Frame length is `SYNC_W`+`DATA_W`+1 cycles: 13 at the defaults.
- The parity bit is valid in cycle N+13; `done`=1 and `ready`=1 in cycle N+14.
- Back-to-back frames: a `load` asserted in the `done` cycle is accepted. The next frame's first bit follows immediately, with no gap beyond that one IDLE cycle.
- Reset mid-frame (`rst`=1 at an edge in any state): all outputs return to reset values after that edge. The captured data is discarded, and no `done` pulse is produced for the aborted frame.
- `rst` and `load` in the same cycle: reset wins and the load is dropped.

## Structure
- Shared package `serial_pkg` holds:
  - the state enum {IDLE, SYNC, DATA, PAR};
  - defaults `DATA_W_DEF`=8, `SYNC_W_DEF`=4, `SYNC_PAT_DEF`=4'b1011.
- The detector side uses the same package.
- One sub-module, `piso_shift`: a `DATA_W`-bit parallel-in/serial-out register with `load` and `shift` enables and an MSB output.
- FSM, counter, parity register and output registers stay in the top.

## Test plan
- **Reset:** hold `rst` 2 cycles with `load`=1 → `ready`=1, `dout`=0, `dout_valid`=0, `done`=0; no frame starts.
- **Single frame, `data_in`=8'hA5:** `dout` sequence over 13 valid cycles is 1011 10100101 0; `done` pulses one cycle after, then `ready`=1.
- **Parity:**
  - 8'h01 → parity bit 1.
  - 8'hFF → parity bit 0.
  - 8'h00 → data bits all 0, parity bit 0.
- **Busy load:** pulse `load` with 8'h3C at bit 5 of an 8'hA5 frame → the frame completes as 8'hA5 and 8'h3C is never sent.
- **Back-to-back:** assert `load`(8'h81) in the `done` cycle → the second frame 1011 10000001 0 starts on the next cycle.
- **Mid-frame reset:** assert `rst` during DATA bit 3 → outputs reach reset values after the edge with no `done`; a subsequent load of 8'h0F transmits a full, correct frame.
